// File: rtl/uart_tx_arb_if.sv
// Bundle between the UART transmit arbiter and its environment: requester byte
// handshakes, the transmitter request/accept pair, and the owner status outputs.
interface uart_tx_arb_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              tx_rd;
  logic [NREQ-1:0]   grant;
  logic              busy;

  // The arbiter serves requests, so it takes the slave view.
  modport slave (
    input  req_valid, req_data, req_last, tx_rd,
    output req_ready, tx_ready, tx_data, grant, busy
  );

  modport master (
    output req_valid, req_data, req_last, tx_rd,
    input  req_ready, tx_ready, tx_data, grant, busy
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Shares one UART byte transmitter between NREQ requesters with message locking.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uart_tx_arb #(
  parameter int          NREQ    = 2,
  parameter int unsigned LOCK_TO = 1023
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_arb_if.slave bus
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = (LOCK_TO < 1) ? 1 : $clog2(LOCK_TO + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_TO);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [7:0]        r_holdData;
  logic [IDX_W-1:0]  r_owner;
  logic [IDX_W-1:0]  r_rrPtr;
  logic              r_locked;
  logic [CNT_W-1:0]  r_lockCnt;

  logic [2*NREQ-1:0] w_dblValid;
  logic [IDX_W-1:0]  w_offset;
  logic [IDX_W:0]    w_sum;
  logic [IDX_W-1:0]  w_winner;
  logic              w_found;
  logic [NREQ-1:0]   w_reqReady;
  logic              w_accept;
  logic [IDX_W-1:0]  w_acceptIdx;
  logic              w_release;
  logic              w_incCnt;
  logic              w_holdEntry;

  // Rotate the valid vector so the scan starts at rr_ptr, then map back.
  always_comb begin
    w_dblValid = {bus.req_valid, bus.req_valid} >> r_rrPtr;
    w_found    = |w_dblValid[NREQ-1:0];
    w_offset   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_dblValid[k]) begin
        w_offset = IDX_W'(k);
      end
    end
    w_sum = {1'b0, r_rrPtr} + {1'b0, w_offset};
    if (w_sum >= (IDX_W + 1)'(NREQ)) begin
      w_sum = w_sum - (IDX_W + 1)'(NREQ);
    end
    w_winner = w_sum[IDX_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_reqReady  = '0;
    w_accept    = 1'b0;
    w_acceptIdx = r_owner;
    w_release   = 1'b0;
    w_incCnt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_reqReady[w_winner] = 1'b1;
          w_accept             = 1'b1;
          w_acceptIdx          = w_winner;
          w_nextState          = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.tx_rd) begin
          if (r_locked) begin
            w_nextState = S_HOLD;
          end else begin
            w_nextState = S_IDLE;
            w_release   = 1'b1;
          end
        end
      end
      S_HOLD: begin
        // Owner keeps ready high even while silent so it can resume at once.
        w_reqReady[r_owner] = 1'b1;
        if (bus.req_valid[r_owner]) begin
          w_accept    = 1'b1;
          w_nextState = S_ISSUE;
        end else if (r_lockCnt == LOCK_MAX) begin
          w_nextState = S_IDLE;
          w_release   = 1'b1;
        end else begin
          w_incCnt = 1'b1;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  assign w_holdEntry = (r_state == S_ISSUE) && bus.tx_rd && r_locked;

`ifndef UART_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] w_nextPtr;
  assign w_nextPtr = (r_owner == IDX_W'(NREQ - 1)) ? '0 : r_owner + IDX_W'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_holdData <= 8'h00;
      r_owner    <= '0;
      r_locked   <= 1'b0;
      r_lockCnt  <= '0;
      r_rrPtr    <= '0;
    end else begin
      if (w_accept) begin
        r_holdData <= bus.req_data[{w_acceptIdx, 3'b000} +: 8];
        r_owner    <= w_acceptIdx;
        r_locked   <= ~bus.req_last[w_acceptIdx];
      end
      if (w_accept || w_holdEntry) begin
        r_lockCnt <= '0;
      end else if (w_incCnt) begin
        r_lockCnt <= r_lockCnt + CNT_W'(1);
      end
`ifdef UART_ARB_FIXED_PRIO_EN
      if (w_release) begin
        r_rrPtr <= '0;
      end
`else
      if (w_release) begin
        r_rrPtr <= w_nextPtr;
      end
`endif
    end
  end

  // Ready is forced low during reset even though the scan sees valid inputs.
  assign bus.req_ready = rst ? '0 : w_reqReady;
  assign bus.tx_ready  = (r_state == S_ISSUE);
  assign bus.tx_data   = r_holdData;
  assign bus.grant     = (r_state == S_IDLE) ? '0 : (NREQ'(1) << r_owner);
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus randomized traffic
// checked cycle by cycle against a message-level reference model.
module tb_uart_tx_arb;
  localparam int NREQ    = 3;
  localparam int LOCK_TO = 10;
`ifdef UART_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  uart_tx_arb_if #(.NREQ(NREQ)) bus ();

  uart_tx_arb #(.NREQ(NREQ), .LOCK_TO(LOCK_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checksTotal  = 0;
  int checksPassed = 0;

  logic       offValid [NREQ];
  logic [7:0] offData  [NREQ];
  logic       offLast  [NREQ];
  logic       txRd;

  // Reference model: who owns the transmitter, whether a byte is waiting on it.
  int         mOwner;
  bit         mHave;
  bit         mLocked;
  int         mWait;
  int         mPtr;
  logic [7:0] mData;
  int         lastAccept;
  int         issueAge;
  int         txDelay;

  logic [7:0]      obsLog   [$];
  logic [NREQ-1:0] grantLog [$];
  logic            obsBusy;
  logic            obsTxReady;
  logic [7:0]      obsTxData;
  logic [NREQ-1:0] obsGrant;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  function automatic int pickWinner(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(mPtr + k) % NREQ]) return (mPtr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mOwner = -1; mHave = 1'b0; mLocked = 1'b0; mWait = 0; mPtr = 0;
    mData = 8'h00; issueAge = 0; lastAccept = -1;
    for (int i = 0; i < NREQ; i++) begin
      offValid[i] = 1'b0; offData[i] = 8'h00; offLast[i] = 1'b0;
    end
  endtask

  task automatic modelRelease();
    if (!FIXED) mPtr = (mOwner + 1) % NREQ;
    mOwner = -1;
  endtask

  task automatic driveBus();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]         = offValid[i];
      bus.req_last[i]          = offLast[i];
      bus.req_data[8*i +: 8]   = offData[i];
    end
    bus.tx_rd = txRd;
  endtask

  task automatic offer(input int i, input logic [7:0] data, input logic last);
    offValid[i] = 1'b1; offData[i] = data; offLast[i] = last;
  endtask

  task automatic txModel(input bit spurious);
    if (mHave) txRd = (issueAge >= txDelay);
    else       txRd = spurious && ($urandom_range(0, 7) == 0);
  endtask

  // One clock cycle: drive at the falling edge, check, advance the model.
  task automatic applyStimulus();
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] expReady;
    int              w;
    for (int i = 0; i < NREQ; i++) v[i] = offValid[i];
    driveBus();
    #1;
    obsBusy = bus.busy; obsTxReady = bus.tx_ready; obsTxData = bus.tx_data; obsGrant = bus.grant;
    w = pickWinner(v);
    expReady = '0;
    if (!mHave) begin
      if (mOwner >= 0) expReady[mOwner] = 1'b1;
      else if (w >= 0) expReady[w] = 1'b1;
    end
    checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));
    checkOutput("tx_ready", 32'(bus.tx_ready), 32'(mHave));
    checkOutput("tx_data", 32'(bus.tx_data), 32'(mData));
    checkOutput("grant", 32'(bus.grant), (mOwner >= 0) ? (32'd1 << mOwner) : 32'd0);
    checkOutput("busy", 32'(bus.busy), 32'(mOwner >= 0));
    lastAccept = -1;
    if (mHave) begin
      if (txRd) begin
        obsLog.push_back(bus.tx_data);
        grantLog.push_back(bus.grant);
        mHave = 1'b0;
        if (mLocked) mWait = 0;
        else modelRelease();
      end else begin
        issueAge++;
      end
    end else if (mOwner >= 0) begin
      if (v[mOwner]) lastAccept = mOwner;
      else if (mWait == LOCK_TO) modelRelease();
      else mWait++;
    end else if (w >= 0) begin
      lastAccept = w;
    end
    if (lastAccept >= 0) begin
      mData = offData[lastAccept]; mLocked = !offLast[lastAccept];
      mOwner = lastAccept; mHave = 1'b1; mWait = 0; issueAge = 0;
      offValid[lastAccept] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic resetDut();
    offValid[0] = 1'b1; offData[0] = 8'hA5; offLast[0] = 1'b1; txRd = 1'b0;
    rst = 1'b1;
    driveBus();
    #1;
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    checkOutput("rst_tx_data", 32'(bus.tx_data), 32'd0);
    checkOutput("rst_grant", 32'(bus.grant), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    modelReset();
    driveBus();
    rst = 1'b0;
    obsLog.delete();
    grantLog.delete();
  endtask

  initial begin
    logic [7:0] lockSeq  [4];
    logic [7:0] got;
    int         lockIdx;
    int         holdCycles;
    int         hiCount;
    int         msgLeft  [NREQ];
    int         silence  [NREQ];
    lockSeq = '{8'h10, 8'h11, 8'h12, 8'hA0};
    txDelay = 1;
    txRd    = 1'b0;
    modelReset();
    resetDut();

    // Single byte from requester 0.
    offer(0, 8'h41, 1'b1);
    for (int c = 0; c < 6; c++) begin txModel(1'b0); applyStimulus(); end
    checkOutput("single_count", 32'(obsLog.size()), 32'd1);
    got = (obsLog.size() > 0) ? obsLog[0] : 8'h00;
    checkOutput("single_data", 32'(got), 32'h41);

    // Two requesters valid continuously.
    resetDut();
    for (int c = 0; c < 60 && grantLog.size() < 4; c++) begin
      for (int i = 0; i < 2; i++) if (!offValid[i]) offer(i, 8'($urandom), 1'b1);
      txModel(1'b0); applyStimulus();
    end
    checkOutput("rr_count", 32'(grantLog.size()), 32'd4);
    for (int n = 0; n < 4; n++) begin
      checkOutput($sformatf("rr_grant%0d", n),
                  (grantLog.size() > n) ? 32'(grantLog[n]) : 32'd0,
                  FIXED ? 32'd1 : ((n % 2 == 0) ? 32'd1 : 32'd2));
    end

    // Locked three-byte message from requester 1 while requester 0 waits.
    resetDut();
    offer(1, lockSeq[0], 1'b0);
    lockIdx = 1;
    txModel(1'b0); applyStimulus();
    for (int c = 0; c < 100 && obsLog.size() < 4; c++) begin
      if (!offValid[1] && lockIdx < 3) begin
        offer(1, lockSeq[lockIdx], lockIdx == 2);
        lockIdx++;
      end
      if (!offValid[0]) offer(0, 8'hA0, 1'b1);
      txModel(1'b0); applyStimulus();
    end
    checkOutput("lock_count", 32'(obsLog.size()), 32'd4);
    for (int n = 0; n < 4; n++) begin
      checkOutput($sformatf("lock_byte%0d", n),
                  (obsLog.size() > n) ? 32'(obsLog[n]) : 32'hFFFF, 32'(lockSeq[n]));
    end

    // Owner goes silent inside a locked message; requester 1 pending.
    resetDut();
    offer(0, 8'h55, 1'b0);
    offer(1, 8'h66, 1'b1);
    for (int c = 0; c < 20 && obsLog.size() < 1; c++) begin txModel(1'b0); applyStimulus(); end
    holdCycles = 0;
    for (int c = 0; c < 40; c++) begin
      txModel(1'b0); applyStimulus();
      if (!obsBusy) break;
      holdCycles++;
    end
    checkOutput("timeout_cycles", 32'(holdCycles), 32'(LOCK_TO + 1));
    txModel(1'b0); applyStimulus();
    checkOutput("timeout_next_grant", 32'(obsGrant), 32'd2);
    for (int c = 0; c < 4; c++) begin txModel(1'b0); applyStimulus(); end

    // Slow transmitter holds off acceptance for 500 cycles.
    resetDut();
    txDelay = 500;
    offer(2, 8'h7E, 1'b1);
    txModel(1'b0); applyStimulus();
    offer(0, 8'h01, 1'b1);
    offer(1, 8'h02, 1'b1);
    hiCount = 0;
    for (int c = 0; c < 600 && obsLog.size() < 1; c++) begin
      txModel(1'b0); applyStimulus();
      if (obsTxReady && obsTxData == 8'h7E) hiCount++;
    end
    checkOutput("busy_tx_cycles", 32'(hiCount), 32'd501);
    got = (obsLog.size() > 0) ? obsLog[0] : 8'h00;
    checkOutput("busy_tx_data", 32'(got), 32'h7E);
    txDelay = 1;

    // Reset while a byte is being offered to the transmitter.
    resetDut();
    offer(0, 8'h33, 1'b1);
    txModel(1'b0); applyStimulus();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    checkOutput("mid_rst_grant", 32'(bus.grant), 32'd0);
    checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    modelReset();
    txRd = 1'b0;
    driveBus();
    rst = 1'b0;
    obsLog.delete();
    offer(0, 8'h44, 1'b1);
    for (int c = 0; c < 10 && obsLog.size() < 1; c++) begin txModel(1'b0); applyStimulus(); end
    got = (obsLog.size() > 0) ? obsLog[0] : 8'h00;
    checkOutput("post_rst_byte", 32'(got), 32'h44);

    // Randomized multi-byte traffic with drops, stalls and stray tx_rd pulses.
    resetDut();
    for (int i = 0; i < NREQ; i++) begin msgLeft[i] = 0; silence[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (silence[i] > 0) silence[i]--;
        else if (offValid[i]) begin
          if ($urandom_range(0, 19) == 0) offValid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          if (msgLeft[i] == 0) msgLeft[i] = $urandom_range(1, 4);
          offer(i, 8'($urandom), msgLeft[i] == 1);
        end
      end
      txModel(1'b1); applyStimulus();
      if (lastAccept >= 0) begin
        msgLeft[lastAccept]--;
        txDelay = $urandom_range(0, 3);
        if (msgLeft[lastAccept] > 0 && $urandom_range(0, 3) == 0)
          silence[lastAccept] = $urandom_range(5, 16);
      end
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
